// File: rtl/vmem_access.sv
// Vector memory-stage access unit: serialises V-bit loads/stores into V/N word beats on an N-bit bus.
// Optional macro VMEM_TIMEOUT_EN adds a per-beat ack timeout that sets the sticky err_o flag.
module vmem_access #(
  parameter int V   = 128,
  parameter int N   = 32,
  parameter int M   = 4,
  parameter int A   = 32,
  parameter int TMO = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_W,
  input  logic         memread_M,
  input  logic         memwrite_M,
  input  logic         regw_M,
  input  logic         regmem_M,
  input  logic [M-1:0] regScr_M,
  input  logic [V-1:0] ALUrslt_M,
  input  logic [V-1:0] wdata_M,
  output logic         regw_W_in,
  output logic         regmem_W_in,
  output logic [M-1:0] regScr_W_in,
  output logic [V-1:0] ALUrslt_W_in,
  output logic [V-1:0] readdata_W_in,
  output logic         stall_M,
  output logic         mem_req,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack,
  output logic         err_o
);

  localparam int B  = V / N;
  localparam int KW = (B > 1) ? $clog2(B) : 1;
  localparam logic [A-1:0] STEP = A'(N / 8);

  if ((V % N) != 0 || B < 1 || TMO < 1) begin : g_bad_cfg
    $error("vmem_access: V must be a positive multiple of N and TMO must be at least 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state, state_nxt;
  logic [KW-1:0] k;
  logic [A-1:0]  base;
  logic [V-1:0]  rbuf;
  logic          start, beat_done, last_beat, tmo_hit;

  assign start     = (state == IDLE) && (memread_M || memwrite_M) && !stall_W;
  assign last_beat = (k == KW'(B - 1));
  assign beat_done = (state == BUSY) && (mem_ack || tmo_hit);

`ifdef VMEM_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] wait_cnt;
  logic          err_q;

  // A beat is abandoned on its TMO-th consecutive cycle without ack.
  assign tmo_hit = (state == BUSY) && !mem_ack && (wait_cnt == CW'(TMO - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state != BUSY || mem_ack || tmo_hit) wait_cnt <= '0;
      else                                     wait_cnt <= wait_cnt + 1'b1;
      if (tmo_hit) err_q <= 1'b1;
    end
  end

  assign err_o = err_q;
`else
  assign tmo_hit = 1'b0;
  assign err_o   = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments, and the load buffer is
  // explicitly reset because readdata_W_in must read 0 after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
      base  <= '0;
      rbuf  <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        base <= ALUrslt_M[A-1:0];
        k    <= '0;
      end else if (beat_done) begin
        if (memread_M) rbuf[N*int'(k) +: N] <= tmo_hit ? '0 : mem_rdata;
        if (!last_beat) k <= k + 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start)                  state_nxt = BUSY;
      BUSY:    if (beat_done && last_beat) state_nxt = DONE;
      DONE:    if (!stall_W)               state_nxt = IDLE;
      default:                             state_nxt = IDLE;
    endcase
  end

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    stall_M   = stall_W;
    regw_W_in = regw_M;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          stall_M   = 1'b1;
          regw_W_in = 1'b0;
        end
      end
      BUSY: begin
        mem_req   = 1'b1;
        mem_we    = memwrite_M;
        mem_addr  = base + STEP * A'(k);
        mem_wdata = wdata_M[N*int'(k) +: N];
        stall_M   = 1'b1;
        regw_W_in = 1'b0;
      end
      default: ;
    endcase
  end

  assign regmem_W_in   = regmem_M;
  assign regScr_W_in   = regScr_M;
  assign ALUrslt_W_in  = ALUrslt_M;
  assign readdata_W_in = rbuf;

endmodule
